data_mem_hs: RTL and testbench

//  Parametrised data memory for the pipelined MIPS core: word/half/byte loads and stores, signed or unsigned load extension.

---
 rtl/data_mem_hs_pkg.sv | 27 ++
 rtl/data_mem_hs_lane_ext.sv | 30 +++
 rtl/data_mem_hs.sv | 152 +++++++++++++++
 tb/tb_data_mem_hs.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/data_mem_hs_pkg.sv
// Shared width codes, FSM state encoding and alignment helper for the data memory.
package dm_pkg;

    typedef enum logic [1:0] {
        DM_WORD = 2'b00,
        DM_HALF = 2'b01,
        DM_BYTE = 2'b10,
        DM_ILL  = 2'b11
    } dm_width_e;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_RD_WAIT
    } dm_state_e;

    // Width 11 is never aligned, so it folds into the same error path.
    function automatic logic lane_ok(input logic [1:0] width, input logic [1:0] a);
        case (width)
            DM_WORD: return (a == 2'b00);
            DM_HALF: return !a[0];
            DM_BYTE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_hs_lane_ext.sv
// Load lane select plus sign/zero extension of the addressed half or byte.
module dm_lane_ext
    import dm_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_width,
    input  logic        i_sign,
    input  logic [1:0]  i_lane,
    output logic [31:0] o_data
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    always_comb begin
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
        case (i_lane)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        case (i_width)
            DM_HALF: o_data = {{16{i_sign & w_half[15]}}, w_half};
            DM_BYTE: o_data = {{24{i_sign & w_byte[7]}}, w_byte};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/data_mem_hs.sv
// Data memory with valid/ready requests, READ_LAT load latency and post-reset clear sweep.
// Define DM_TRACE_EN to print a trace line for every successful store.
module data_mem_hs
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned READ_LAT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_width,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [31:0]   r_mem [DEPTH_WORDS];
    dm_state_e     r_state;
    dm_state_e     w_state_nxt;
    logic [AW-1:0] r_clr_ptr;
    logic [2:0]    r_lat_cnt;
    logic          r_pend_err;
    logic [31:0]   r_pend_data;

    logic          w_acc;
    logic          w_err;
    logic          w_st_ok;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_old;
    logic [31:0]   w_merged;
    logic [31:0]   w_ld_data;

    assign w_acc   = req_valid & req_ready;
    assign w_idx   = req_addr[AW+1:2];
    assign w_old   = r_mem[w_idx];
    assign w_err   = !lane_ok(req_width, req_addr[1:0]) || ({2'b00, req_addr[31:2]} >= DEPTH_WORDS);
    assign w_st_ok = w_acc & req_we & !w_err;

    dm_lane_ext u_lane_ext (
        .i_word  (w_old),
        .i_width (req_width),
        .i_sign  (req_sign),
        .i_lane  (req_addr[1:0]),
        .o_data  (w_ld_data)
    );

    always_comb begin
        w_merged = w_old;
        case (req_width)
            DM_WORD: w_merged = req_wdata;
            DM_HALF: begin
                if (req_addr[1]) w_merged[31:16] = req_wdata[15:0];
                else             w_merged[15:0]  = req_wdata[15:0];
            end
            DM_BYTE: begin
                case (req_addr[1:0])
                    2'd0:    w_merged[7:0]   = req_wdata[7:0];
                    2'd1:    w_merged[15:8]  = req_wdata[7:0];
                    2'd2:    w_merged[23:16] = req_wdata[7:0];
                    default: w_merged[31:24] = req_wdata[7:0];
                endcase
            end
            default: ;
        endcase
    end

    // Array has no reset; the CLEAR sweep zeroes it after every reset release.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR)
            r_mem[r_clr_ptr] <= '0;
        else if (w_st_ok)
            r_mem[w_idx] <= w_merged;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_CLEAR;
        else        r_state <= w_state_nxt;
    end

    // Leaving RD_WAIT when the count is at 1 puts the response and the return
    // of req_ready in the same cycle, READ_LAT cycles after acceptance.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR:   if (r_clr_ptr == '1) w_state_nxt = ST_IDLE;
            ST_IDLE:    if (w_acc && !req_we && READ_LAT > 1) w_state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: if (r_lat_cnt == 3'd1) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_CLEAR;
        endcase
    end

    always_comb begin
        req_ready = (r_state == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clr_ptr   <= '0;
            r_lat_cnt   <= '0;
            r_pend_err  <= 1'b0;
            r_pend_data <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            if (r_state == ST_CLEAR)
                r_clr_ptr <= r_clr_ptr + 1'b1;
            if (w_acc) begin
                if (req_we || READ_LAT == 1) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= w_err;
                    rsp_rdata <= (req_we || w_err) ? '0 : w_ld_data;
                end else begin
                    r_lat_cnt   <= 3'(READ_LAT - 1);
                    r_pend_err  <= w_err;
                    r_pend_data <= w_err ? '0 : w_ld_data;
                end
            end
            if (r_state == ST_RD_WAIT) begin
                r_lat_cnt <= r_lat_cnt - 3'd1;
                if (r_lat_cnt == 3'd1) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= r_pend_err;
                    rsp_rdata <= r_pend_data;
                end
            end
        end
    end

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset && w_st_ok)
            $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, w_merged);
    end
`else
    logic w_unused_pc;
    assign w_unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_data_mem_hs.sv
// Randomized bench for data_mem_hs against a byte-array reference model.
module tb_data_mem_hs;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned LAT   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_width;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [7:0]  mb [4*DEPTH];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_mem_hs #(.DEPTH_WORDS(DEPTH), .READ_LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_width (req_width),
        .req_sign  (req_sign),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory as little-endian bytes; access size from width, extension by arithmetic.
    task automatic model_access(input logic we, input logic [1:0] w, input logic s,
                                input logic [31:0] a, input logic [31:0] d,
                                output logic err, output logic [31:0] rd);
        int unsigned nb;
        logic [31:0] v;
        nb  = (w == 2'd0) ? 4 : (w == 2'd1) ? 2 : 1;
        err = (w == 2'd3) || (a % nb != 0) || (a / 4 >= DEPTH);
        rd  = '0;
        if (err) return;
        if (we) begin
            for (int unsigned i = 0; i < nb; i++) mb[a + i] = d[8*i +: 8];
        end else begin
            v = '0;
            for (int unsigned i = 0; i < nb; i++) v = v | ({24'b0, mb[a + i]} << (8*i));
            if (s && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            rd = v;
        end
    endtask

    task automatic measure_sweep();
        int n    = 0;
        int seen = 0;
        check("rdy_after_rst", {31'b0, req_ready}, 32'd0);
        while (!req_ready && n < 4*DEPTH) begin
            @(posedge clk); #1;
            n++;
            if (rsp_valid) seen++;
        end
        check("sweep_len", n, DEPTH);
        check("no_rsp_sweep", seen, 0);
        for (int unsigned i = 0; i < 4*DEPTH; i++) mb[i] = 8'h00;
    endtask

    task automatic do_req(input logic we, input logic [1:0] w, input logic s,
                          input logic [31:0] a, input logic [31:0] d);
        logic        eerr;
        logic [31:0] erd;
        int n = 1;
        check("rdy_idle", {31'b0, req_ready}, 32'd1);
        model_access(we, w, s, a, d, eerr, erd);
        req_valid = 1'b1; req_we = we; req_width = w; req_sign = s;
        req_addr  = a;    req_wdata = d; req_pc = $urandom;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom; req_sign = ~s;
        while (!rsp_valid && n < 8) begin
            check("rdy_wait", {31'b0, req_ready}, 32'd0);
            @(posedge clk); #1;
            n++;
        end
        check("lat", n, we ? 1 : LAT);
        check("err", {31'b0, rsp_err}, {31'b0, eerr});
        check("rdata", rsp_rdata, erd);
    endtask

    initial begin
        logic [1:0]  w;
        logic [31:0] a;
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_width = 2'd0;
        req_sign = 1'b0; req_addr = '0; req_wdata = '0; req_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, req_ready}, 32'd0);
        check("rst_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_err",   {31'b0, rsp_err},   32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        reset = 1'b1;
        measure_sweep();
        do_req(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);

        // Byte loads of a stored word, signed and unsigned.
        do_req(1'b1, 2'd0, 1'b0, 32'h0, 32'h8765_4321);
        do_req(1'b0, 2'd2, 1'b1, 32'h3, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h3, 32'h0);
        check("byte_s_const", 32'hFFFF_FF87, {{24{mb[3][7]}}, mb[3]});

        // Half merge, then word and half reads; load then store back-to-back.
        do_req(1'b1, 2'd0, 1'b0, 32'h4, 32'h1234_5678);
        do_req(1'b1, 2'd1, 1'b0, 32'h6, 32'h0000_BEEF);
        do_req(1'b0, 2'd0, 1'b0, 32'h4, 32'h0);
        do_req(1'b1, 2'd2, 1'b0, 32'h9, 32'h0000_00A5);
        do_req(1'b0, 2'd1, 1'b1, 32'h6, 32'h0);
        do_req(1'b0, 2'd2, 1'b1, 32'h9, 32'h0);

        // Error cases leave memory untouched.
        do_req(1'b1, 2'd0, 1'b0, 32'h2, 32'hFFFF_FFFF);
        do_req(1'b0, 2'd1, 1'b0, 32'h1, 32'h0);
        do_req(1'b1, 2'd3, 1'b0, 32'h0, 32'hFFFF_FFFF);
        do_req(1'b0, 2'd3, 1'b0, 32'h4, 32'h0);
        do_req(1'b1, 2'd0, 1'b0, 4*DEPTH, 32'hFFFF_FFFF);
        do_req(1'b0, 2'd0, 1'b0, 4*DEPTH + 4, 32'h0);
        do_req(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        do_req(1'b0, 2'd0, 1'b0, 32'h4, 32'h0);

        for (int k = 0; k < 300; k++) begin
            w = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 7) begin
                a = $urandom_range(0, 4*DEPTH - 1);
                if (w == 2'd0) a[1:0] = 2'b00;
                if (w == 2'd1) a[0] = 1'b0;
            end else begin
                a = $urandom_range(0, 4*DEPTH + 15);
            end
            do_req(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)), a, $urandom);
        end

        // Reset while a load is waiting: response dropped, sweep restarts.
        do_req(1'b1, 2'd0, 1'b0, 32'h8, 32'hDEAD_BEEF);
        req_valid = 1'b1; req_we = 1'b0; req_width = 2'd0; req_addr = 32'h8;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("in_rd_wait", {31'b0, req_ready}, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("rsp_in_rst", {31'b0, rsp_valid}, 32'd0);
        end
        reset = 1'b1;
        measure_sweep();
        do_req(1'b0, 2'd0, 1'b0, 32'h8, 32'h0);
        do_req(1'b0, 2'd0, 1'b0, 32'h4, 32'h0);
        check("cleared_const", 32'h0, {mb[11], mb[10], mb[9], mb[8]});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
